pc_sequencer: RTL and testbench

- Top-level execution controller for the single-cycle processor.
- Owns the program counter and the start/done handshake with the test harness.
- Selects the next PC each cycle: sequential, branch target, or hold. Branch targets come from a lookup table.
- Gates the architectural write enables from the control decoder through Exec_En, so no register or memory write happens outside program execution.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/branch_lut.sv | 17 +
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned LUT_W_DEF = 5;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned LUT_DEPTH = 1 << LUT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Branch-target table; regenerated by the assembler flow.
    localparam logic [PC_W_DEF-1:0] BRANCH_TABLE [LUT_DEPTH] = '{
        10'h004, 10'h03E, 10'h100, 10'h020, 10'h080, 10'h0C0, 10'h200, 10'h3FC,
        10'h010, 10'h018, 10'h028, 10'h030, 10'h038, 10'h048, 10'h050, 10'h058,
        10'h060, 10'h068, 10'h070, 10'h078, 10'h088, 10'h090, 10'h098, 10'h0A0,
        10'h0A8, 10'h0B0, 10'h0B8, 10'h0C8, 10'h0D0, 10'h0D8, 10'h0E0, 10'h0E8
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational ROM mapping a branch-target index to an instruction address.
module branch_lut
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] target_idx,
    output logic [PC_W-1:0]  target_c
);

    // Table read, resized to the program-counter width.
    always_comb begin
        target_c = PC_W'(BRANCH_TABLE[target_idx]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Execution controller: start/done handshake, PC selection and write gating.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned LUT_W = LUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             branch,
    input  logic             br_cond,
    input  logic             halt,
    input  logic [LUT_W-1:0] target_idx,
    output logic [PC_W-1:0]  pc,
    output logic             exec_en,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [PC_W-1:0]  PC_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_e       state_q;
    seq_state_e       state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovr_nxt;
    logic [PC_W-1:0]  lut_target_c;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .target_idx (target_idx),
        .target_c   (lut_target_c)
    );

    // State, PC, counter and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc          <= '0;
            cycle_count <= '0;
            overrun     <= 1'b0;
            exec_en     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            pc          <= pc_nxt;
            cycle_count <= cnt_nxt;
            overrun     <= ovr_nxt;
            exec_en     <= (state_nxt == ST_RUN);
            done        <= (state_nxt == ST_DONE);
        end
    end

    // Next-state, next-PC, counter and overrun selection.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc;
        cnt_nxt   = cycle_count;
        ovr_nxt   = overrun;

        case (state_q)
            ST_IDLE: begin
                pc_nxt = '0;
                if (start) begin
                    state_nxt = ST_ARM;
                    cnt_nxt   = '0;
                    ovr_nxt   = 1'b0;
                end
            end

            ST_ARM: begin
                pc_nxt  = '0;
                cnt_nxt = '0;
                ovr_nxt = 1'b0;
                if (!start) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                // The executing cycle always counts, including the halt cycle.
                cnt_nxt = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
                if (start) begin
                    state_nxt = ST_ARM;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                    ovr_nxt   = 1'b0;
                end else if (halt) begin
                    state_nxt = ST_DONE;
                end else if (branch && br_cond) begin
                    pc_nxt = lut_target_c;
                end else if (pc == PC_LAST) begin
                    // Falling off the end of memory stops rather than wrapping.
                    state_nxt = ST_DONE;
                    ovr_nxt   = 1'b1;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                    ovr_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model predicts each cycle.
module tb_pc_sequencer;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned LUT_W = 5;
    localparam int unsigned CNT_W = 16;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             exec_en;
        logic             done;
        logic             overrun;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             branch;
    logic             br_cond;
    logic             halt;
    logic [LUT_W-1:0] target_idx;
    logic [PC_W-1:0]  pc;
    logic             exec_en;
    logic             done;
    logic             overrun;
    logic [CNT_W-1:0] cycle_count;

    int n_checks;
    int n_fail;

    exp_t sb_q[$];

    int               m_state;
    logic [PC_W-1:0]  m_pc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovr;

    pc_sequencer #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .branch      (branch),
        .br_cond     (br_cond),
        .halt        (halt),
        .target_idx  (target_idx),
        .pc          (pc),
        .exec_en     (exec_en),
        .done        (done),
        .overrun     (overrun),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Known branch-table entries used by this bench.
    function automatic logic [PC_W-1:0] lut_ref(input logic [LUT_W-1:0] idx);
        case (idx)
            5'd0:    return 10'h004;
            5'd1:    return 10'h03E;
            5'd3:    return 10'h020;
            5'd7:    return 10'h3FC;
            default: return 10'h000;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic st, input logic br,
                              input logic bc, input logic hl, input logic [LUT_W-1:0] ti);
        if (!rst) begin
            m_state = M_IDLE;
            m_pc    = '0;
            m_cnt   = '0;
            m_ovr   = 1'b0;
        end else if (m_state == M_RUN) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (st) begin
                m_state = M_ARM; m_pc = '0; m_cnt = '0; m_ovr = 1'b0;
            end else if (hl) begin
                m_state = M_DONE;
            end else if (br && bc) begin
                m_pc = lut_ref(ti);
            end else if (m_pc == 10'h3FF) begin
                m_state = M_DONE; m_ovr = 1'b1;
            end else begin
                m_pc = m_pc + 10'd1;
            end
        end else if (m_state == M_ARM) begin
            m_pc = '0; m_cnt = '0; m_ovr = 1'b0;
            if (!st) m_state = M_RUN;
        end else if (st) begin
            m_state = M_ARM; m_pc = '0; m_cnt = '0; m_ovr = 1'b0;
        end
    endtask

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic cycle(input logic rst, input logic st, input logic br,
                         input logic bc, input logic hl, input logic [LUT_W-1:0] ti);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset_n    = rst;
        start      = st;
        branch     = br;
        br_cond    = bc;
        halt       = hl;
        target_idx = ti;
        model_step(rst, st, br, bc, hl, ti);
        e.pc      = m_pc;
        e.exec_en = (m_state == M_RUN);
        e.done    = (m_state == M_DONE);
        e.overrun = m_ovr;
        e.cnt     = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("sb_pc",      32'(pc),          32'(got.pc));
            check("sb_exec_en", 32'(exec_en),     32'(got.exec_en));
            check("sb_done",    32'(done),        32'(got.done));
            check("sb_overrun", 32'(overrun),     32'(got.overrun));
            check("sb_cnt",     32'(cycle_count), 32'(got.cnt));
        end
    endtask

    task automatic step();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic arm(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic take(input logic [LUT_W-1:0] ti);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ti);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_state    = M_IDLE;
        m_pc       = '0;
        m_cnt      = '0;
        m_ovr      = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        branch     = 1'b0;
        br_cond    = 1'b0;
        halt       = 1'b0;
        target_idx = '0;

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Arm for three cycles, then release; PC counts from zero.
        arm(3);
        check("arm_pc", 32'(pc), 32'h0);
        step();
        check("run0_pc", 32'(pc), 32'h0);
        check("run0_exec", 32'(exec_en), 32'h1);
        steps(3);
        check("run3_pc", 32'(pc), 32'h3);

        // Reset mid-run at PC=0x12.
        steps(15);
        check("pre_rst_pc", 32'(pc), 32'h12);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_exec", 32'(exec_en), 32'h0);
        check("rst_cnt", 32'(cycle_count), 32'h0);

        // Straight-line run with halt at PC=7.
        arm(3);
        step();
        steps(7);
        check("pre_halt_pc", 32'(pc), 32'h7);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("halt_done", 32'(done), 32'h1);
        check("halt_exec", 32'(exec_en), 32'h0);
        check("halt_pc", 32'(pc), 32'h7);
        check("halt_cnt", 32'(cycle_count), 32'd8);
        steps(2);
        check("done_hold_cnt", 32'(cycle_count), 32'd8);
        arm(1);
        check("rearm_pc", 32'(pc), 32'h0);
        check("rearm_cnt", 32'(cycle_count), 32'h0);

        // Taken branch at PC=5, then not-taken branch at 0x020.
        step();
        steps(5);
        take(5'd3);
        check("br_taken_pc", 32'(pc), 32'h020);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
        check("br_not_taken_pc", 32'(pc), 32'h021);

        // Abort to ARM, then halt and taken branch together at PC=9.
        arm(1);
        step();
        steps(9);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
        check("halt_wins_pc", 32'(pc), 32'h9);
        check("halt_wins_done", 32'(done), 32'h1);

        // Start mid-run at PC=0x40.
        arm(1);
        step();
        take(5'd1);
        steps(2);
        check("pre_abort_pc", 32'(pc), 32'h040);
        arm(1);
        check("abort_pc", 32'(pc), 32'h0);
        check("abort_cnt", 32'(cycle_count), 32'h0);
        check("abort_exec", 32'(exec_en), 32'h0);

        // Run off the end of memory.
        step();
        take(5'd7);
        steps(3);
        check("last_pc", 32'(pc), 32'h3FF);
        step();
        check("runoff_done", 32'(done), 32'h1);
        check("runoff_ovr", 32'(overrun), 32'h1);
        check("runoff_pc", 32'(pc), 32'h3FF);
        step();
        check("runoff_ovr_hold", 32'(overrun), 32'h1);
        arm(1);
        check("rearm_ovr", 32'(overrun), 32'h0);

        // Taken branch on the last address follows the branch.
        step();
        take(5'd7);
        steps(3);
        take(5'd0);
        check("last_br_pc", 32'(pc), 32'h004);
        check("last_br_ovr", 32'(overrun), 32'h0);
        check("last_br_exec", 32'(exec_en), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("final_done", 32'(done), 32'h1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
